cpu_trace_capture: RTL and testbench

Parametrised, synthesizable trace buffer that records per-cycle or per-instruction probe samples from the multicycle CPU (PC, instruction, control word) into a circular memory. Capture starts on an arm command, stops a programmable number of samples after a PC-match trigger, and is drained oldest-first through a read handshake. It sits beside `MultiCycle_CPU` on the probe buses, so the bench and on-chip debug can observe execution without decoding waveforms by hand.

---
 rtl/cpu_trace_capture_if.sv | 12 +
 rtl/cpu_trace_capture.sv | 126 ++++++++++++
 tb/tb_cpu_trace_capture.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_capture_if.sv
// Read-drain handshake of the CPU trace buffer.
interface cpu_trace_capture_if #(
  parameter int unsigned DW = 96
);
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;

  modport master (output rd_en, input rd_data, input rd_valid, input rd_last);
  modport slave  (input rd_en, output rd_data, output rd_valid, output rd_last);
endinterface

// File: rtl/cpu_trace_capture.sv
// Circular trace buffer for MultiCycle_CPU probes: arm, PC trigger, post-trigger
// window, then oldest-first drain over the read handshake.
module cpu_trace_capture #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned PROBE_W = 48,
  parameter int unsigned TS_W    = 16,
  parameter int unsigned DEPTH   = 16,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned DW     = TS_W + ADDR_W + PROBE_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         pc_i,
  input  logic [PROBE_W-1:0]        probe_i,
  input  logic                      sample_en,
  input  logic                      arm,
  input  logic [ADDR_W-1:0]         trig_pc,
  input  logic [AW-1:0]             post_len,
  cpu_trace_capture_if.slave        rd,
  output logic [1:0]                state_o,
  output logic [AW:0]               count_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

  logic [1:0]      state;
  logic [TS_W-1:0] ts;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, post_cnt, wr_ptr_nx;
  logic [AW:0]     count, rd_idx, count_nx;
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q, rd_last_q;
  logic            wr_en, trig_hit, enter_done, rd_go, rd_end;

  always_comb begin
    wr_en      = sample_en && ((state == S_ARMED && !arm) || state == S_POST);
    trig_hit   = state == S_ARMED && sample_en && !arm && pc_i == trig_pc;
    enter_done = (trig_hit && post_len == '0) ||
                 (state == S_POST && sample_en && post_cnt == AW'(1));
    wr_ptr_nx  = wr_ptr + 1'b1;
    count_nx   = (count == FULL) ? count : count + 1'b1;
    rd_go      = state == S_DONE && rd.rd_en && rd_idx != count;
    rd_end     = rd_go && (rd_idx + 1'b1 == count);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ts, pc_i, probe_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      count      <= '0;
      rd_idx     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      ts         <= ts + 1'b1;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      if (wr_en) begin
        wr_ptr <= wr_ptr_nx;
        count  <= count_nx;
      end
      // The oldest entry is located from the post-write pointer and count.
      if (enter_done) begin
        rd_ptr <= (count_nx == FULL) ? wr_ptr_nx : '0;
        rd_idx <= '0;
      end
      case (state)
        S_IDLE: begin
          if (arm) begin
            wr_ptr <= '0;
            count  <= '0;
            state  <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (arm) begin
            wr_ptr <= '0;
            count  <= '0;
          end else if (trig_hit) begin
            post_cnt <= post_len;
            state    <= (post_len == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (sample_en) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1)) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (rd_go) begin
            rd_data_q  <= mem[rd_ptr];
            rd_valid_q <= 1'b1;
            rd_last_q  <= rd_end;
            rd_ptr     <= rd_ptr + 1'b1;
            rd_idx     <= rd_idx + 1'b1;
            if (rd_end) begin
              state <= S_IDLE;
              count <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd.rd_data  = rd_data_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign state_o     = state;
  assign count_o     = count;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Directed bench for cpu_trace_capture: capture/trigger windows, wrap, qualification,
// re-arm, ignored inputs and asynchronous reset during a drain.
module tb_cpu_trace_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i, trig_pc;
  logic [47:0] probe_i;
  logic        sample_en, arm;
  logic [3:0]  post_len;
  logic [1:0]  state_o;
  logic [4:0]  count_o;
  logic [15:0] cyc;

  logic [95:0] sb[$];
  int n_chk = 0;
  int n_bad = 0;

  cpu_trace_capture_if #(.DW(96)) rd_bus ();

  cpu_trace_capture #(.ADDR_W(32), .PROBE_W(48), .TS_W(16), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .probe_i(probe_i),
    .sample_en(sample_en), .arm(arm), .trig_pc(trig_pc), .post_len(post_len),
    .rd(rd_bus), .state_o(state_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 16'd1;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int held();
    return (sb.size() > 16) ? 16 : sb.size();
  endfunction

  task automatic capture(input logic [31:0] tpc, input logic [3:0] plen, input int period,
                         input int rearm_at, input bit poke_post, output int edges);
    logic [31:0] p = 32'h0;
    int  post_left = -1;
    int  ktrig = 0;
    bit  poked = 1'b0;
    bit  done = 1'b0;
    logic [1:0] exp_st;
    edges = 0;
    sb.delete();
    trig_pc = tpc;
    post_len = plen;
    arm = 1'b1; sample_en = 1'b0; pc_i = 32'hFFFF_FFFF;
    tick();
    arm = 1'b0;
    chk("armed", 96'(state_o), 96'd1);
    chk("arm_count", 96'(count_o), 96'd0);
    for (int k = 0; k < 400; k++) begin
      bit en, rearm, poke_now;
      en = (k % period) == 0;
      rearm = (k == rearm_at);
      poke_now = 1'b0;
      sample_en = en; pc_i = p; probe_i = {16'(k), ~p};
      arm = rearm;
      if (poke_post && post_left > 0 && !poked) begin
        arm = 1'b1; rd_bus.rd_en = 1'b1; poked = 1'b1; poke_now = 1'b1;
      end
      if (rearm) sb.delete();
      else if (en) begin
        sb.push_back({cyc, p, probe_i});
        if (post_left < 0 && p == tpc) begin
          post_left = int'(plen); ktrig = k;
        end else if (post_left > 0) post_left--;
      end
      exp_st = (post_left < 0) ? 2'd1 : (post_left == 0) ? 2'd3 : 2'd2;
      tick();
      arm = 1'b0; rd_bus.rd_en = 1'b0;
      chk("cap_state", 96'(state_o), 96'(exp_st));
      chk("cap_count", 96'(count_o), 96'(held()));
      if (poke_now) chk("post_rd_valid", 96'(rd_bus.rd_valid), 96'd0);
      if (en) p += 32'd4;
      if (exp_st == 2'd3) begin
        edges = k - ktrig + 1; done = 1'b1; break;
      end
    end
    sample_en = 1'b0;
    if (!done) chk("capture_timeout", 96'd0, 96'd1);
  endtask

  task automatic drain(input bit gap, output logic [95:0] first, output logic [95:0] last);
    int n = held();
    int base = sb.size() - n;
    first = '0; last = '0;
    for (int i = 0; i < n; i++) begin
      rd_bus.rd_en = 1'b1;
      tick();
      rd_bus.rd_en = 1'b0;
      chk("rd_valid", 96'(rd_bus.rd_valid), 96'd1);
      chk("rd_data", rd_bus.rd_data, sb[base+i]);
      chk("rd_last", 96'(rd_bus.rd_last), 96'(i == n-1));
      if (i == 0) first = rd_bus.rd_data;
      last = rd_bus.rd_data;
      if (gap && i < n-1) begin
        tick();
        chk("gap_valid", 96'(rd_bus.rd_valid), 96'd0);
      end
    end
    chk("drain_idle", 96'(state_o), 96'd0);
    chk("drain_count", 96'(count_o), 96'd0);
  endtask

  initial begin
    logic [95:0] f, l;
    int e;
    rst_n = 1'b0; pc_i = '0; probe_i = '0; sample_en = 1'b0; arm = 1'b0;
    trig_pc = '0; post_len = '0; rd_bus.rd_en = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_state", 96'(state_o), 96'd0);
    chk("rst_count", 96'(count_o), 96'd0);
    chk("rst_valid", 96'(rd_bus.rd_valid), 96'd0);
    chk("rst_last", 96'(rd_bus.rd_last), 96'd0);
    chk("rst_data", rd_bus.rd_data, 96'd0);

    // Basic per-cycle capture
    capture(32'h20, 4'd3, 1, -1, 1'b0, e);
    chk("basic_edges", 96'(e), 96'd4);
    chk("basic_count", 96'(count_o), 96'd12);
    drain(1'b0, f, l);
    chk("basic_first_pc", 96'(f[79:48]), 96'h00);
    chk("basic_last_pc", 96'(l[79:48]), 96'h2C);

    // Wrap: 16 newest entries ending 5 samples after 0x100
    capture(32'h100, 4'd5, 1, -1, 1'b0, e);
    chk("wrap_count", 96'(count_o), 96'd16);
    drain(1'b1, f, l);
    chk("wrap_first_pc", 96'(f[79:48]), 96'hD8);
    chk("wrap_last_pc", 96'(l[79:48]), 96'h114);
    chk("wrap_ts_span", 96'(16'(l[95:80] - f[95:80])), 96'd15);

    // Per-instruction qualification every 3rd cycle
    capture(32'h20, 4'd3, 3, -1, 1'b0, e);
    chk("qual_count", 96'(count_o), 96'd12);
    drain(1'b0, f, l);
    chk("qual_ts_span", 96'(16'(l[95:80] - f[95:80])), 96'd33);

    // post_len extremes
    capture(32'h10, 4'd0, 1, -1, 1'b0, e);
    chk("plen0_edges", 96'(e), 96'd1);
    drain(1'b0, f, l);
    chk("plen0_last_pc", 96'(l[79:48]), 96'h10);
    capture(32'h100, 4'd15, 1, -1, 1'b0, e);
    chk("plen15_count", 96'(count_o), 96'd16);
    drain(1'b0, f, l);
    chk("plen15_first_pc", 96'(f[79:48]), 96'h100);
    chk("plen15_last_pc", 96'(l[79:48]), 96'h13C);

    // Re-arm in ARMED, arm/rd_en poked in POST
    capture(32'h40, 4'd2, 1, 3, 1'b1, e);
    chk("rearm_count", 96'(count_o), 96'd15);
    drain(1'b0, f, l);
    chk("rearm_first_pc", 96'(f[79:48]), 96'h10);
    rd_bus.rd_en = 1'b1;
    tick();
    rd_bus.rd_en = 1'b0;
    chk("idle_rd_valid", 96'(rd_bus.rd_valid), 96'd0);

    // Asynchronous reset in the middle of a drain
    capture(32'h20, 4'd3, 1, -1, 1'b0, e);
    for (int i = 0; i < 3; i++) begin
      rd_bus.rd_en = 1'b1;
      tick();
      chk("pre_rst_valid", 96'(rd_bus.rd_valid), 96'd1);
    end
    rd_bus.rd_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 96'(rd_bus.rd_valid), 96'd0);
    chk("async_rst_state", 96'(state_o), 96'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_count", 96'(count_o), 96'd0);
    capture(32'h8, 4'd1, 1, -1, 1'b0, e);
    drain(1'b0, f, l);
    chk("ts_restart", 96'(f[95:80]), 96'd2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
